coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage directly upstream of drink_machine_top.
- Turns raw coin-mechanism sensor events into clean single-cycle nickel_in / dime_in / quarter_in pulses.
- Synchronises and debounces the sensor, classifies the coin code, and buffers accepted coins in a small FIFO so bursts are not lost while the machine is busy.
- Issues rejects for invalid or unacceptable coins and keeps saturating accept/reject counters for service diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high samples needed to qualify a coin (legal range 1..15).
- FIFO_DEPTH, 4, number of accepted coins buffered (power of two, 2..16).
- GAP_CYCLES, 1, minimum idle cycles between two issued coin pulses (legal range 0..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset; 0 = in reset.
- coin_detect  input  1  raw sensor, asynchronous to clk, high while a coin is in the gate.
- coin_code  input  2  coin class: 00 invalid, 01 nickel, 10 dime, 11 quarter. Source must hold it stable while coin_detect is high.
- accept_en  input  1  1 = coins may be accepted (driven from ~empty of downstream).
- hold  input  1  1 = do not start a new output pulse (driven from dispense).
- nickel_in  output  1  one-cycle pulse to downstream.
- dime_in  output  1  one-cycle pulse to downstream.
- quarter_in  output  1  one-cycle pulse to downstream.
- reject  output  1  one-cycle pulse; drives the coin-return gate.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  coins currently buffered.
- coins_accepted  output  8  saturating count of coins pushed into the FIFO.
- coins_rejected  output  8  saturating count of reject pulses.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, both counters 0, FIFO flushed, synchroniser flops 0, debounce FSM = WAIT_LOW, issue FSM = IDLE.
- Synchroniser: coin_detect passes through two flops (det_s). Only det_s is used.
- Debounce FSM:
  - IDLE: det_s=1 -> QUAL with cnt=1. If DEBOUNCE_CYCLES=1, capture immediately.
  - QUAL: det_s=1 -> cnt+1; when cnt reaches DEBOUNCE_CYCLES, capture -> WAIT_LOW. det_s=0 -> IDLE with no event (glitch filtered).
  - WAIT_LOW: det_s=0 -> IDLE. Exactly one capture per coin.
- Reset state is WAIT_LOW: a coin held across reset release is not counted.
- Capture classification, evaluated on the capture edge:
  - reject if coin_code=00, or accept_en=0, or FIFO full. FIFO full is judged before any same-edge pop.
  - otherwise push coin_code into the FIFO.
  - reject is asserted for exactly the cycle after the capture edge.
- Latency: let k be the first edge at which coin_detect is sampled high.
  - Capture occurs at edge k+1+DEBOUNCE_CYCLES.
  - With an idle issue FSM, empty FIFO and hold=0, the matching output is high from edge k+2+DEBOUNCE_CYCLES to k+3+DEBOUNCE_CYCLES.
- Issue FSM:
  - IDLE: FIFO non-empty and hold=0 -> pop the head, assert the matching output for one cycle -> PULSE.
  - PULSE -> GAP for GAP_CYCLES cycles, then IDLE. If GAP_CYCLES=0, go straight to IDLE.
  - hold is sampled only in IDLE; a pulse already started always completes.
  - At most one of nickel_in, dime_in, quarter_in is high in any cycle.
- FIFO ordering: strict order of acceptance. Push and pop on the same edge is allowed when the FIFO is not full. fifo_count reflects the post-edge value.
- Counters: coins_accepted increments on push; coins_rejected increments on reject. Both hold at 255, no wrap.
- Coin arriving while a previous coin is mid-debounce is impossible (one gate). A det_s low gap shorter than DEBOUNCE_CYCLES between coins still yields one capture per high period longer than DEBOUNCE_CYCLES.

Test Plan:
- Reset, then a single dime (coin_detect high for 10 cycles, code 10, accept_en=1) -> dime_in high for exactly one cycle at edge k+6; reject=0; coins_accepted=1; fifo_count back to 0.
- coin_detect high for 2 cycles, then low -> no output pulse, no reject, counters unchanged.
- Code 00, then a quarter with accept_en=0 -> two reject pulses; coins_rejected=2; no quarter_in.
- hold=1 while 5 nickels arrive (DEPTH=4) -> 4 pushed, 5th rejected, fifo_count=4. Release hold -> 4 nickel_in pulses separated by 1 idle cycle (GAP=1).
- Sequence nickel, dime, quarter under hold, then release -> nickel_in, dime_in, quarter_in pulses in that order, never two high together.
- Assert reset with 3 coins queued and coin_detect still high -> outputs 0, fifo_count=0, counters 0. After release, no pulse until coin_detect goes low and a new coin arrives.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin-mechanism interface: sensor and control inputs, coin pulses and diagnostic outputs.
// The master side drives the sensor and control inputs. The slave side is the acceptor.
interface coin_acceptor_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          coin_detect;
  logic [1:0]                    coin_code;
  logic                          accept_en;
  logic                          hold;
  logic                          nickel_in;
  logic                          dime_in;
  logic                          quarter_in;
  logic                          reject;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [7:0]                    coins_accepted;
  logic [7:0]                    coins_rejected;

  modport master (
    output coin_detect, coin_code, accept_en, hold,
    input  nickel_in, dime_in, quarter_in, reject, fifo_count, coins_accepted, coins_rejected
  );

  modport slave (
    input  coin_detect, coin_code, accept_en, hold,
    output nickel_in, dime_in, quarter_in, reject, fifo_count, coins_accepted, coins_rejected
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: syncs and debounces the coin sensor, then classifies each coin.
// Accepted coins are queued in a FIFO and issued as spaced one-cycle pulses.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  coin_acceptor_if.slave   bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] DB_IDLE     = 2'd0;
  localparam logic [1:0] DB_QUAL     = 2'd1;
  localparam logic [1:0] DB_WAIT_LOW = 2'd2;

  localparam logic [1:0] ISS_IDLE  = 2'd0;
  localparam logic [1:0] ISS_PULSE = 2'd1;
  localparam logic [1:0] ISS_GAP   = 2'd2;

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CYCLES);

  logic          r_sync1, r_det_s;
  logic [1:0]    r_sync_vld;
  logic [1:0]    r_db_state, w_db_state_d;
  logic [3:0]    r_db_cnt, w_db_cnt_d;
  logic          w_capture;

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_empty, w_push, w_pop, w_reject;
  logic [1:0]    w_head;

  logic [1:0]    r_iss_state, w_iss_state_d;
  logic [2:0]    r_gap_cnt, w_gap_cnt_d;

  logic          r_nickel, r_dime, r_quarter, r_reject;
  logic [7:0]    r_accepted, r_rejected;

  // r_sync_vld marks when det_s reflects a real post-reset sample, so a coin held
  // across reset release is never mistaken for a new low-to-high transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_det_s    <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync1    <= bus.coin_detect;
      r_det_s    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  always_comb begin
    w_db_state_d = r_db_state;
    w_db_cnt_d   = r_db_cnt;
    w_capture    = 1'b0;
    case (r_db_state)
      DB_IDLE: begin
        if (r_det_s) begin
          w_db_cnt_d = 4'd1;
          if (DEBOUNCE_CYCLES == 1) begin
            w_capture    = 1'b1;
            w_db_state_d = DB_WAIT_LOW;
          end else begin
            w_db_state_d = DB_QUAL;
          end
        end
      end
      DB_QUAL: begin
        if (r_det_s) begin
          w_db_cnt_d = r_db_cnt + 4'd1;
          if (w_db_cnt_d == DB_TARGET) begin
            w_capture    = 1'b1;
            w_db_state_d = DB_WAIT_LOW;
          end
        end else begin
          w_db_state_d = DB_IDLE;
        end
      end
      DB_WAIT_LOW: begin
        if (!r_det_s && r_sync_vld[1]) w_db_state_d = DB_IDLE;
      end
      default: w_db_state_d = DB_WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_state <= DB_WAIT_LOW;
      r_db_cnt   <= 4'd0;
    end else begin
      r_db_state <= w_db_state_d;
      r_db_cnt   <= w_db_cnt_d;
    end
  end

  // Fullness is judged on the pre-edge count, so a same-edge pop cannot make room.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = w_capture && (bus.coin_code != 2'b00) && bus.accept_en && !w_full;
  assign w_reject = w_capture && !w_push;
  assign w_pop    = (r_iss_state == ISS_IDLE) && !w_empty && !bus.hold;
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 2'b00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.coin_code;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The IDLE decision cycle is itself one idle cycle, so GAP holds GAP_CYCLES-1 more.
  always_comb begin
    w_iss_state_d = r_iss_state;
    w_gap_cnt_d   = r_gap_cnt;
    case (r_iss_state)
      ISS_IDLE: begin
        if (w_pop) w_iss_state_d = ISS_PULSE;
      end
      ISS_PULSE: begin
        if (GAP_CYCLES <= 1) begin
          w_iss_state_d = ISS_IDLE;
        end else begin
          w_iss_state_d = ISS_GAP;
          w_gap_cnt_d   = 3'(GAP_CYCLES - 1);
        end
      end
      ISS_GAP: begin
        if (r_gap_cnt <= 3'd1) w_iss_state_d = ISS_IDLE;
        else                   w_gap_cnt_d   = r_gap_cnt - 3'd1;
      end
      default: w_iss_state_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iss_state <= ISS_IDLE;
      r_gap_cnt   <= 3'd0;
      r_nickel    <= 1'b0;
      r_dime      <= 1'b0;
      r_quarter   <= 1'b0;
      r_reject    <= 1'b0;
      r_accepted  <= 8'd0;
      r_rejected  <= 8'd0;
    end else begin
      r_iss_state <= w_iss_state_d;
      r_gap_cnt   <= w_gap_cnt_d;
      r_nickel    <= w_pop && (w_head == 2'b01);
      r_dime      <= w_pop && (w_head == 2'b10);
      r_quarter   <= w_pop && (w_head == 2'b11);
      r_reject    <= w_reject;
      if (w_push && (r_accepted != 8'hff))   r_accepted <= r_accepted + 8'd1;
      if (w_reject && (r_rejected != 8'hff)) r_rejected <= r_rejected + 8'd1;
    end
  end

  assign bus.nickel_in      = r_nickel;
  assign bus.dime_in        = r_dime;
  assign bus.quarter_in     = r_quarter;
  assign bus.reject         = r_reject;
  assign bus.fifo_count     = r_count;
  assign bus.coins_accepted = r_accepted;
  assign bus.coins_rejected = r_rejected;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: debounce latency, rejects, FIFO ordering, gap and reset.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int   n_nick = 0, n_dime = 0, n_quart = 0, n_rej = 0, n_multi = 0, cyc = 0;
  int   pulse_cyc[$];
  int   pulse_code[$];
  int   snap;

  coin_acceptor_if #(.FIFO_DEPTH(4)) bus_if ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .GAP_CYCLES     (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.nickel_in)  begin n_nick  <= n_nick + 1;  pulse_cyc.push_back(cyc); pulse_code.push_back(1); end
    if (bus_if.dime_in)    begin n_dime  <= n_dime + 1;  pulse_cyc.push_back(cyc); pulse_code.push_back(2); end
    if (bus_if.quarter_in) begin n_quart <= n_quart + 1; pulse_cyc.push_back(cyc); pulse_code.push_back(3); end
    if (bus_if.reject) n_rej <= n_rej + 1;
    if ((32'(bus_if.nickel_in) + 32'(bus_if.dime_in) + 32'(bus_if.quarter_in)) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin(input logic [1:0] code, input int hi, input int lo);
    bus_if.coin_code   = code;
    bus_if.coin_detect = 1'b1;
    tick(hi);
    bus_if.coin_detect = 1'b0;
    tick(lo);
  endtask

  initial begin
    bus_if.coin_detect = 1'b0;
    bus_if.coin_code   = 2'b00;
    bus_if.accept_en   = 1'b1;
    bus_if.hold        = 1'b0;

    // Reset values
    tick(2);
    chk("rst_nickel", 32'(bus_if.nickel_in), 0);
    chk("rst_reject", 32'(bus_if.reject), 0);
    chk("rst_count", 32'(bus_if.fifo_count), 0);
    chk("rst_acc", 32'(bus_if.coins_accepted), 0);
    reset = 1'b1;
    tick(4);

    // Single dime: capture at k+5, dime_in high only after edge k+6
    bus_if.coin_code   = 2'b10;
    bus_if.coin_detect = 1'b1;
    tick(6);
    chk("dime_k5_out", 32'(bus_if.dime_in), 0);
    chk("dime_k5_count", 32'(bus_if.fifo_count), 1);
    chk("dime_k5_acc", 32'(bus_if.coins_accepted), 1);
    chk("dime_k5_rej", 32'(bus_if.reject), 0);
    tick(1);
    chk("dime_k6_out", 32'(bus_if.dime_in), 1);
    chk("dime_k6_count", 32'(bus_if.fifo_count), 0);
    tick(1);
    chk("dime_k7_out", 32'(bus_if.dime_in), 0);
    tick(2);
    bus_if.coin_detect = 1'b0;
    tick(6);
    chk("dime_pulses", n_dime, 1);
    chk("dime_no_reject", n_rej, 0);

    // Two-cycle glitch is filtered
    bus_if.coin_detect = 1'b1;
    tick(2);
    bus_if.coin_detect = 1'b0;
    tick(10);
    chk("glitch_pulses", n_nick + n_dime + n_quart, 1);
    chk("glitch_rej", n_rej, 0);
    chk("glitch_acc", 32'(bus_if.coins_accepted), 1);
    chk("glitch_rejcnt", 32'(bus_if.coins_rejected), 0);

    // Invalid code, then quarter with accept_en low
    coin(2'b00, 8, 5);
    bus_if.accept_en = 1'b0;
    coin(2'b11, 8, 5);
    bus_if.accept_en = 1'b1;
    chk("rej_rejcnt", 32'(bus_if.coins_rejected), 2);
    chk("rej_pulses", n_rej, 2);
    chk("rej_no_quarter", n_quart, 0);
    chk("rej_acc", 32'(bus_if.coins_accepted), 1);

    // Five nickels under hold: FIFO fills at 4, fifth rejected
    bus_if.hold = 1'b1;
    repeat (5) coin(2'b01, 8, 4);
    chk("full_count", 32'(bus_if.fifo_count), 4);
    chk("full_acc", 32'(bus_if.coins_accepted), 5);
    chk("full_rejcnt", 32'(bus_if.coins_rejected), 3);
    chk("full_no_nickel", n_nick, 0);
    pulse_cyc.delete();
    pulse_code.delete();
    bus_if.hold = 1'b0;
    tick(1);
    chk("drain_p0", 32'(bus_if.nickel_in), 1);
    tick(1);
    chk("drain_gap0", 32'(bus_if.nickel_in), 0);
    tick(1);
    chk("drain_p1", 32'(bus_if.nickel_in), 1);
    tick(8);
    chk("drain_nickels", n_nick, 4);
    chk("drain_count", 32'(bus_if.fifo_count), 0);
    chk("drain_space01", pulse_cyc[1] - pulse_cyc[0], 2);
    chk("drain_space12", pulse_cyc[2] - pulse_cyc[1], 2);
    chk("drain_space23", pulse_cyc[3] - pulse_cyc[2], 2);

    // Ordering: nickel, dime, quarter
    bus_if.hold = 1'b1;
    coin(2'b01, 8, 4);
    coin(2'b10, 8, 4);
    coin(2'b11, 8, 4);
    chk("order_count", 32'(bus_if.fifo_count), 3);
    pulse_code.delete();
    bus_if.hold = 1'b0;
    tick(10);
    chk("order_n", pulse_code.size(), 3);
    chk("order_0", pulse_code[0], 1);
    chk("order_1", pulse_code[1], 2);
    chk("order_2", pulse_code[2], 3);
    chk("order_onehot", n_multi, 0);
    chk("order_acc", 32'(bus_if.coins_accepted), 8);
    chk("order_rejcnt", 32'(bus_if.coins_rejected), 3);

    // Reset with coins queued and a coin still in the gate
    bus_if.hold = 1'b1;
    repeat (3) coin(2'b10, 8, 4);
    chk("pre_rst_count", 32'(bus_if.fifo_count), 3);
    bus_if.coin_detect = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(bus_if.fifo_count), 0);
    chk("arst_acc", 32'(bus_if.coins_accepted), 0);
    chk("arst_rejcnt", 32'(bus_if.coins_rejected), 0);
    tick(2);
    bus_if.hold = 1'b0;
    snap = n_nick + n_dime + n_quart;
    reset = 1'b1;
    tick(12);
    chk("held_no_pulse", n_nick + n_dime + n_quart, snap);
    chk("held_acc", 32'(bus_if.coins_accepted), 0);
    chk("held_rejcnt", 32'(bus_if.coins_rejected), 0);
    bus_if.coin_detect = 1'b0;
    tick(5);
    coin(2'b10, 8, 6);
    chk("post_rst_pulse", n_nick + n_dime + n_quart, snap + 1);
    chk("post_rst_acc", 32'(bus_if.coins_accepted), 1);
    chk("post_rst_onehot", n_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
